// File: rtl/output_buffer.sv
// output_buffer: result store written by the accumulator and drained to the
// host reader as a valid/ready burst. Each entry carries a valid bit so that
// the reader can tell freshly written results from stale ones.
// Build option: define OUTPUT_BUFFER_CLEAR_ON_READ_EN so that a handshake
// on a word also clears the valid bit of the entry it came from.
module output_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] output_data,
   input  logic [ADDR_W-1:0] output_buffer_addr,
   input  logic              output_buffer_enable,
   input  logic              buf_clear,
   input  logic              drain_start,
   input  logic [ADDR_W-1:0] drain_addr,
   input  logic [ADDR_W:0]   drain_len,
   output logic              drain_busy,
   output logic              drain_done,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_stale,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DEPTH-1:0]  entry_valid
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   // Result storage; contents deliberately survive reset.
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic [DEPTH-1:0]  w_valid_next;

   logic [ADDR_W-1:0] r_ptr;
   logic [ADDR_W:0]   r_remaining;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_stale;
   logic              r_rd_valid;
   logic              r_done;

   logic              w_load;
   logic              w_fetch;
   logic              w_accept;
   logic              w_done_next;
   logic              w_fwd;

   // A write landing on the entry being fetched this cycle is forwarded so
   // the reader sees the newest value (write-first behaviour).
   assign w_fwd = output_buffer_enable && (output_buffer_addr == r_ptr);

   // Memory write port; accepted in every FSM state.
   always_ff @(posedge clk) begin
      if (output_buffer_enable) begin
         r_mem[output_buffer_addr] <= output_data;
      end
   end

   // Per-entry valid bit next-state: a write beats clear and clear-on-read.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      logic w_wr_hit;
      logic w_rd_clr;
      assign w_wr_hit = output_buffer_enable && (output_buffer_addr == ADDR_W'(gi));
`ifdef OUTPUT_BUFFER_CLEAR_ON_READ_EN
      assign w_rd_clr = w_accept && (r_ptr == ADDR_W'(gi));
`else
      assign w_rd_clr = 1'b0;
`endif
      assign w_valid_next[gi] = w_wr_hit ? 1'b1 :
                                (buf_clear || w_rd_clr) ? 1'b0 : r_valid[gi];
   end

   // Valid bit register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
      end else begin
         r_valid <= w_valid_next;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM next-state and control strobes.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_fetch      = 1'b0;
      w_accept     = 1'b0;
      w_done_next  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (drain_start) begin
               if (drain_len != '0) begin
                  w_load       = 1'b1;
                  w_state_next = ST_FETCH;
               end else begin
                  // Empty burst: nothing to stream, just report completion.
                  w_done_next = 1'b1;
               end
            end
         end
         ST_FETCH: begin
            w_fetch      = 1'b1;
            w_state_next = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (r_rd_valid && rd_ready) begin
               w_accept = 1'b1;
               if (r_remaining == (ADDR_W+1)'(1)) begin
                  w_state_next = ST_IDLE;
                  w_done_next  = 1'b1;
               end else begin
                  w_state_next = ST_FETCH;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Burst pointer and remaining-word counter; pointer wraps modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_remaining <= '0;
      end else if (w_load) begin
         r_ptr       <= drain_addr;
         r_remaining <= drain_len;
      end else if (w_accept) begin
         r_ptr       <= r_ptr + ADDR_W'(1);
         r_remaining <= r_remaining - (ADDR_W+1)'(1);
      end
   end

   // Read output register: loaded only in FETCH, frozen while presenting.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data  <= '0;
         r_rd_stale <= 1'b0;
         r_rd_valid <= 1'b0;
      end else if (w_fetch) begin
         r_rd_data  <= w_fwd ? output_data : r_mem[r_ptr];
         r_rd_stale <= w_fwd ? 1'b0 : ~r_valid[r_ptr];
         r_rd_valid <= 1'b1;
      end else if (w_accept) begin
         r_rd_valid <= 1'b0;
      end
   end

   // Completion pulse, one cycle after the final handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_done <= 1'b0;
      end else begin
         r_done <= w_done_next;
      end
   end

   assign drain_busy  = (r_state != ST_IDLE);
   assign drain_done  = r_done;
   assign rd_data     = r_rd_data;
   assign rd_stale    = r_rd_stale;
   assign rd_valid    = r_rd_valid;
   assign entry_valid = r_valid;

endmodule

// File: tb/tb_output_buffer.sv
// Directed bench for output_buffer: expected words are queued when a drain
// is launched and popped on every rd_valid/rd_ready handshake.
// Honours OUTPUT_BUFFER_CLEAR_ON_READ_EN the same way the design does.
module tb_output_buffer;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] output_data;
   logic [ADDR_W-1:0] output_buffer_addr;
   logic              output_buffer_enable;
   logic              buf_clear;
   logic              drain_start;
   logic [ADDR_W-1:0] drain_addr;
   logic [ADDR_W:0]   drain_len;
   logic              drain_busy;
   logic              drain_done;
   logic [DATA_W-1:0] rd_data;
   logic              rd_stale;
   logic              rd_valid;
   logic              rd_ready;
   logic [DEPTH-1:0]  entry_valid;

   int                total = 0;
   int                bad = 0;
   int                done_cnt = 0;
   bit                done_seen = 1'b0;
   int                ncyc;
   logic [DATA_W:0]   exp_q [$];

   output_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .output_data          (output_data),
      .output_buffer_addr   (output_buffer_addr),
      .output_buffer_enable (output_buffer_enable),
      .buf_clear            (buf_clear),
      .drain_start          (drain_start),
      .drain_addr           (drain_addr),
      .drain_len            (drain_len),
      .drain_busy           (drain_busy),
      .drain_done           (drain_done),
      .rd_data              (rd_data),
      .rd_stale             (rd_stale),
      .rd_valid             (rd_valid),
      .rd_ready             (rd_ready),
      .entry_valid          (entry_valid)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: score the handshake due at the coming edge, then pass it.
   task automatic step();
      logic [DATA_W:0] e;
      @(negedge clk);
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("extra_word", 64'(exp_q.size()), 64'd1);
         end else begin
            e = exp_q.pop_front();
            $display("word data=%08h stale=%0d", rd_data, rd_stale);
            check("rd_data", 64'(rd_data), 64'(e[DATA_W-1:0]));
            check("rd_stale", 64'(rd_stale), 64'(e[DATA_W]));
         end
      end
      if (drain_done === 1'b1) begin
         done_cnt++;
         done_seen = 1'b1;
         check("done_rd_valid", 64'(rd_valid), 64'd0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      output_buffer_addr   = a;
      output_data          = d;
      output_buffer_enable = 1'b1;
      step();
      output_buffer_enable = 1'b0;
   endtask

   task automatic start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] n);
      drain_addr  = a;
      drain_len   = n;
      drain_start = 1'b1;
      step();
      drain_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      done_seen = 1'b0;
      n = 0;
      while (!done_seen && n < budget) begin
         step();
         n++;
      end
      check("done_timeout", 64'(done_seen), 64'd1);
   endtask

   // Directed sequence.
   initial begin
      rst = 1'b1;
      output_data = '0;
      output_buffer_addr = '0;
      output_buffer_enable = 1'b0;
      buf_clear = 1'b0;
      drain_start = 1'b0;
      drain_addr = '0;
      drain_len = '0;
      rd_ready = 1'b0;
      step();
      step();
      check("rst_busy", 64'(drain_busy), 64'd0);
      check("rst_done", 64'(drain_done), 64'd0);
      check("rst_valid", 64'(rd_valid), 64'd0);
      check("rst_stale", 64'(rd_stale), 64'd0);
      check("rst_data", 64'(rd_data), 64'd0);
      check("rst_entry_valid", 64'(entry_valid), 64'd0);
      rst = 1'b0;

      // Basic burst 0..3 with the reader always ready.
      for (int i = 0; i < 4; i++) write_word(ADDR_W'(i), DATA_W'(32'hA + i));
      check("wr_entry_valid", 64'(entry_valid), 64'h000F);
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, DATA_W'(32'hA + i)});
      rd_ready = 1'b1;
      done_cnt = 0;
      start(4'd0, 5'd4);
      check("fetch_rd_valid", 64'(rd_valid), 64'd0);
      check("fetch_busy", 64'(drain_busy), 64'd1);
      step();
      check("first_rd_valid", 64'(rd_valid), 64'd1);
      wait_done(30, ncyc);
      check("burst_cycles", 64'(ncyc), 64'd8);
      step();
      check("burst_done_cnt", 64'(done_cnt), 64'd1);
      check("burst_done_low", 64'(drain_done), 64'd0);
      check("burst_q_empty", 64'(exp_q.size()), 64'd0);

      // Wrap-around 14,15,0; entry 1 must not be read.
      write_word(4'd14, 32'h1);
      write_word(4'd15, 32'h2);
      write_word(4'd0, 32'h3);
      exp_q.push_back({1'b0, 32'h1});
      exp_q.push_back({1'b0, 32'h2});
      exp_q.push_back({1'b0, 32'h3});
      done_cnt = 0;
      start(4'd14, 5'd3);
      wait_done(30, ncyc);
      step();
      step();
      check("wrap_q_empty", 64'(exp_q.size()), 64'd0);
      check("wrap_done_cnt", 64'(done_cnt), 64'd1);
      check("wrap_busy", 64'(drain_busy), 64'd0);

      // Backpressure with rewrites of the presented entry, then forwarding.
      rd_ready = 1'b0;
      write_word(4'd6, 32'h66);
      write_word(4'd7, 32'h77);
      exp_q.push_back({1'b0, 32'h66});
      exp_q.push_back({1'b0, 32'h7F});
      start(4'd6, 5'd2);
      step();
      for (int i = 0; i < 5; i++) begin
         output_buffer_addr   = 4'd6;
         output_data          = 32'h900 + i;
         output_buffer_enable = 1'b1;
         step();
         check("hold_data", 64'(rd_data), 64'h66);
         check("hold_valid", 64'(rd_valid), 64'd1);
      end
      output_buffer_enable = 1'b0;
      rd_ready = 1'b1;
      step();
      write_word(4'd7, 32'h7F);
      wait_done(20, ncyc);
      check("fwd_q_empty", 64'(exp_q.size()), 64'd0);

      // Clear with a same-cycle write, then a stale/fresh pair.
      write_word(4'd4, 32'h44);
      buf_clear = 1'b1;
      write_word(4'd5, 32'h55);
      buf_clear = 1'b0;
      check("clear_entry_valid", 64'(entry_valid), 64'h0020);
      exp_q.push_back({1'b1, 32'h44});
      exp_q.push_back({1'b0, 32'h55});
      start(4'd4, 5'd2);
      wait_done(20, ncyc);
      check("stale_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef OUTPUT_BUFFER_CLEAR_ON_READ_EN
      check("stale_entry_valid", 64'(entry_valid), 64'h0000);
`else
      check("stale_entry_valid", 64'(entry_valid), 64'h0020);
`endif

      // Zero-length drain: only drain_done pulses.
      start(4'd0, 5'd0);
      check("len0_done", 64'(drain_done), 64'd1);
      check("len0_busy", 64'(drain_busy), 64'd0);
      check("len0_valid", 64'(rd_valid), 64'd0);
      step();
      check("len0_done_low", 64'(drain_done), 64'd0);

      // drain_start while busy is ignored.
      rd_ready = 1'b0;
      exp_q.push_back({1'b1, 32'h3});
      start(4'd0, 5'd1);
      start(4'd8, 5'd5);
      check("busy_busy", 64'(drain_busy), 64'd1);
      check("busy_valid", 64'(rd_valid), 64'd1);
      rd_ready = 1'b1;
      done_cnt = 0;
      wait_done(20, ncyc);
      step();
      step();
      check("busy_q_empty", 64'(exp_q.size()), 64'd0);
      check("busy_idle", 64'(drain_busy), 64'd0);
      check("busy_done_cnt", 64'(done_cnt), 64'd1);

      // Reset mid-burst aborts without drain_done.
      rd_ready = 1'b0;
      start(4'd0, 5'd4);
      step();
      check("abort_pre_valid", 64'(rd_valid), 64'd1);
      rst = 1'b1;
      done_cnt = 0;
      step();
      check("abort_busy", 64'(drain_busy), 64'd0);
      check("abort_done", 64'(drain_done), 64'd0);
      check("abort_valid", 64'(rd_valid), 64'd0);
      check("abort_stale", 64'(rd_stale), 64'd0);
      check("abort_data", 64'(rd_data), 64'd0);
      check("abort_entry_valid", 64'(entry_valid), 64'd0);
      rst = 1'b0;
      step();
      step();
      step();
      check("abort_no_done", 64'(done_cnt), 64'd0);
      check("abort_idle", 64'(drain_busy), 64'd0);

      // Valid bits after a full read of 0..3.
      for (int i = 0; i < 4; i++) write_word(ADDR_W'(i), DATA_W'(32'hA + i));
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, DATA_W'(32'hA + i)});
      rd_ready = 1'b1;
      start(4'd0, 5'd4);
      wait_done(40, ncyc);
      step();
      check("cor_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef OUTPUT_BUFFER_CLEAR_ON_READ_EN
      check("cor_entry_valid", 64'(entry_valid), 64'h0000);
`else
      check("cor_entry_valid", 64'(entry_valid), 64'h000F);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/output_buffer.md
# output_buffer

- Storage endpoint for the accumulator's output write port: captures `output_data` words at `output_buffer_addr` when `output_buffer_enable` is high.
- Streams stored results to the host-side reader as a drain burst over a valid/ready handshake.
- Tracks a per-entry valid bit so the reader can tell freshly written results from stale ones.
- Sits between the Accumulator and the host/DMA read path.

## Interface

Parameters:
- `DATA_W`, 32, word width; matches the accumulator's `output_data`.
- `DEPTH`, 16, number of entries; must be a power of two.
- `ADDR_W`, 4, address width; equals log2(DEPTH).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `output_data`  in  DATA_W  write data from the accumulator.
- `output_buffer_addr`  in  ADDR_W  write address.
- `output_buffer_enable`  in  1  write strobe; one word per cycle.
- `buf_clear`  in  1  clears all valid bits.
- `drain_start`  in  1  starts a drain burst; single-cycle pulse.
- `drain_addr`  in  ADDR_W  first address of the burst.
- `drain_len`  in  ADDR_W+1  words to drain, 0..DEPTH.
- `drain_busy`  out  1  burst in progress.
- `drain_done`  out  1  one-cycle pulse after the last word is accepted.
- `rd_data`  out  DATA_W  streamed word.
- `rd_stale`  out  1  entry's valid bit was 0 when the word was fetched.
- `rd_valid`  out  1  `rd_data`/`rd_stale` are valid.
- `rd_ready`  in  1  reader accepts the word.
- `entry_valid`  out  DEPTH  per-entry valid bits.

## Operation

Write path:
- `output_buffer_enable`=1 writes `mem[output_buffer_addr]` and sets its valid bit at the next edge.
- Writes are accepted in every state, including during a drain.

Clear:
- `buf_clear` zeroes all valid bits; memory contents are untouched.
- A write in the same cycle wins for its entry: that entry ends with valid=1.

FSM states: IDLE, FETCH, PRESENT.
- IDLE → FETCH on `drain_start` with `drain_len`≠0. Load the read pointer from `drain_addr` and the remaining count from `drain_len`.
- `drain_start` with `drain_len`=0: no burst; `drain_done` pulses next cycle.
- `drain_start` outside IDLE is ignored.
- FETCH → PRESENT: register `mem[ptr]` into `rd_data` and `!valid[ptr]` into `rd_stale`, and assert `rd_valid`. A same-cycle write to `ptr` is forwarded (write-first).
- PRESENT: hold while `rd_ready`=0.
  - `rd_data`/`rd_stale` stay frozen, even if `ptr` is rewritten.
  - On `rd_valid`&&`rd_ready`: ptr = (ptr+1) mod DEPTH; remaining -= 1.
  - If remaining was 1, go to IDLE and pulse `drain_done`; otherwise go to FETCH.
- Address arithmetic wraps modulo DEPTH. `drain_len`=DEPTH reads every entry once, starting anywhere.
- `drain_busy` = (state≠IDLE).
- `buf_clear` mid-drain does not abort the burst. Words fetched afterwards report `rd_stale`=1 unless rewritten.

## Timing

- Reset values:
  - `drain_busy`, `drain_done`, `rd_valid`, `rd_stale` = 0.
  - `rd_data` = 0.
  - `entry_valid` = 0.
  - FSM = IDLE.
- Memory contents are not reset.
- `rst` mid-burst aborts immediately: the outputs above take their reset values on the next edge, with no `drain_done`.
- Write-to-`entry_valid` latency: 1 cycle.
- `drain_start` at edge N: FETCH during cycle N+1, `rd_valid` high from N+2.
- Throughput: one word per 2 cycles with `rd_ready` held high.
- `drain_done` is high the cycle after the final handshake, with `rd_valid`=0 in that cycle.
- `rd_valid` never drops without a handshake, except on `rst`.

## Configuration

- `OUTPUT_BUFFER_CLEAR_ON_READ_EN` defined:
  - A handshake on a word clears the valid bit of its entry at the same edge.
  - A same-cycle write to that entry wins (valid stays 1).
- Not defined: valid bits change only on write, `buf_clear` or `rst`.

## Test plan

- Reset, then write 0xA..0xD to addr 0..3; `drain_start` addr=0 len=4 with `rd_ready`=1.
  - Required: 0xA,0xB,0xC,0xD with `rd_stale`=0.
  - First `rd_valid` 2 cycles after start; `drain_done` pulses once, after the 4th handshake.
- Wrap-around: write addr 14,15,0 = 0x1,0x2,0x3; drain addr=14 len=3.
  - Required: 0x1,0x2,0x3, then addr 1 is not read.
- Backpressure and forwarding:
  - Hold `rd_ready`=0 for 5 cycles in PRESENT while rewriting the presented address: `rd_data` stays unchanged.
  - A write to the next address during its FETCH cycle is what streams out.
- Stale and clear:
  - `buf_clear` with a same-cycle write to addr 5 → `entry_valid`=0x0020.
  - A drain of addr 4..5 gives `rd_stale`=1 then 0.
- Edge cases:
  - `drain_len`=0 → only `drain_done` pulses.
  - `drain_start` while busy → ignored.
  - `rst` mid-burst → all outputs 0 next cycle, no `drain_done`.
- With `OUTPUT_BUFFER_CLEAR_ON_READ_EN`: after draining addr 0..3, `entry_valid`[3:0]=0. Without the macro they stay 0xF.
